// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared SPI NOR flash constants, FSM states and command word helper.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int         ADDR_W   = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_DATA,
    ST_DONE,
    ST_GAP
  } state_t;

  function automatic logic [31:0] read_cmd_word(input logic [ADDR_W-1:0] addr);
    return {CMD_READ, addr};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SCK divider and mode-0 bit shifter; one run covers command and data bits.
// A run is a leading low half, nbits full SCK periods, then done one cycle before the final low half ends.
module spi_shift_engine #(
  parameter int CLK_DIV = 2,
  parameter int NB_W    = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NB_W-1:0] nbits,
  input  logic [31:0]     tx_word,
  input  logic            miso,
  output logic            sck,
  output logic            mosi,
  output logic [7:0]      rx_byte,
  output logic            byte_strobe,
  output logic            done
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic            run;
  logic            lead;
  logic [DIV_W-1:0] div;
  logic [NB_W-1:0] bits_left;
  logic [31:0]     tx;
  logic [7:0]      rx;
  logic [7:0]      rx_next;
  logic [2:0]      bit_cnt;
  logic            end_low;

  assign rx_next = {rx[6:0], miso};
  // done is raised early so the owner can lift CS exactly CLK_DIV cycles after the last fall
  assign end_low = (int'(div) == CLK_DIV - 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      lead        <= 1'b0;
      div         <= '0;
      bits_left   <= '0;
      tx          <= '0;
      rx          <= '0;
      bit_cnt     <= '0;
      sck         <= 1'b0;
      mosi        <= 1'b0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      done        <= 1'b0;
      if (!run) begin
        if (start) begin
          run       <= 1'b1;
          lead      <= 1'b1;
          div       <= '0;
          mosi      <= tx_word[31];
          tx        <= {tx_word[30:0], 1'b0};
          bits_left <= nbits;
          bit_cnt   <= '0;
        end
      end else if (sck) begin
        if (div == DIV_LAST) begin
          sck  <= 1'b0;
          div  <= '0;
          mosi <= tx[31];
          tx   <= {tx[30:0], 1'b0};
          if (bits_left == '0 && CLK_DIV == 1) begin
            done <= 1'b1;
            run  <= 1'b0;
          end
        end else begin
          div <= div + 1'b1;
        end
      end else if (!lead && bits_left == '0 && end_low) begin
        done <= 1'b1;
        run  <= 1'b0;
      end else if (div == DIV_LAST) begin
        sck       <= 1'b1;
        div       <= '0;
        lead      <= 1'b0;
        rx        <= rx_next;
        bit_cnt   <= bit_cnt + 3'd1;
        bits_left <= bits_left - 1'b1;
        if (bit_cnt == 3'd7) begin
          byte_strobe <= 1'b1;
          rx_byte     <= rx_next;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_flash_read_arbiter.sv
// rtl/spi_flash_read_arbiter.sv - round-robin READ (0x03) arbiter sharing one SPI NOR flash between two clients.
module spi_flash_read_arbiter
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic [LEN_W-1:0]  req1_len,
  output logic [1:0]        req_ack,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_owner,
  output logic              rd_last,
  output logic              xfer_done,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int               NB_W     = LEN_W + 4;
  localparam int               GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  state_t            state;
  logic              rr;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        cmd_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic              eng_start;
  logic [NB_W-1:0]   eng_nbits;
  logic [7:0]        eng_rx;
  logic              eng_byte;
  logic              eng_done;

  assign grant     = (req_valid == 2'b11) ? rr : req_valid[1];
  assign eng_start = (state == ST_CS_SETUP) && spi_cs && (len_q != '0);
  // command and data run as one continuous SCK burst
  assign eng_nbits = {1'b0, len_q, 3'b000} + NB_W'(32);

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV),
    .NB_W   (NB_W)
  ) u_engine (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (eng_start),
    .nbits      (eng_nbits),
    .tx_word    (read_cmd_word(addr_q)),
    .miso       (spi_miso),
    .sck        (spi_clk),
    .mosi       (spi_mosi),
    .rx_byte    (eng_rx),
    .byte_strobe(eng_byte),
    .done       (eng_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr        <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cmd_cnt   <= '0;
      gap_cnt   <= '0;
      req_ack   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_owner  <= 1'b0;
      rd_last   <= 1'b0;
      xfer_done <= 1'b0;
      busy      <= 1'b0;
      spi_cs    <= 1'b1;
    end else begin
      req_ack   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      xfer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_ack  <= grant ? 2'b10 : 2'b01;
            rr       <= ~grant;
            rd_owner <= grant;
            addr_q   <= grant ? req1_addr : req0_addr;
            len_q    <= grant ? req1_len : req0_len;
            cmd_cnt  <= '0;
            busy     <= 1'b1;
            state    <= ST_CS_SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_CS_SETUP: begin
          if (spi_cs) begin
            if (len_q == '0) begin
              xfer_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              spi_cs <= 1'b0;
            end
          end else if (spi_clk) begin
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          // the four bytes clocked in while the command goes out are discarded
          if (eng_byte) begin
            cmd_cnt <= cmd_cnt + 2'd1;
            if (cmd_cnt == 2'd3) state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (eng_byte) begin
            rd_valid <= 1'b1;
            rd_data  <= eng_rx;
            rd_last  <= (len_q == LEN_W'(1));
            len_q    <= len_q - 1'b1;
          end else if (eng_done) begin
            spi_cs    <= 1'b1;
            xfer_done <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// tb/tb_spi_flash_read_arbiter.sv - directed bench for spi_flash_read_arbiter with a mode-0 flash model.
module tb_spi_flash_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [23:0] req0_addr, req1_addr;
  logic [15:0] req0_len, req1_len;
  logic [1:0]  req_ack;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_owner, rd_last, xfer_done, busy;
  logic        spi_cs, spi_clk, spi_mosi;
  logic        spi_miso = 1'b0;

  int vec = 0;
  int err = 0;

  spi_flash_read_arbiter #(.CLK_DIV(2), .LEN_W(16), .CS_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_len(req0_len), .req1_len(req1_len),
    .req_ack(req_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_owner(rd_owner), .rd_last(rd_last), .xfer_done(xfer_done),
    .busy(busy), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // flash model: capture command on SCK rise, drive data MSB first on SCK fall
  logic [7:0]  miso_bytes [0:15];
  logic [31:0] cmd_word = '0;
  int          rise_cnt = 0;
  int          model_idx;
  logic [7:0]  model_byte;
  always @(posedge spi_clk or negedge spi_clk or posedge spi_cs) begin
    if (spi_cs) begin
      rise_cnt = 0;
      spi_miso = 1'b0;
    end else if (spi_clk) begin
      if (rise_cnt < 32) cmd_word = {cmd_word[30:0], spi_mosi};
      rise_cnt++;
    end else if (rise_cnt >= 32) begin
      model_idx  = rise_cnt - 32;
      model_byte = miso_bytes[(model_idx / 8) % 16];
      spi_miso   = model_byte[7 - (model_idx % 8)];
    end
  end

  logic [9:0] rx_log [0:63];
  int         rx_n = 0;
  int         ack_log [0:63];
  int         ack_n = 0;
  int         done_cnt = 0;
  logic       done_owner = 1'b0;
  int         cs_low_total = 0;
  int         hi_run = 0;
  int         last_hi_run = 0;
  always @(negedge clk) begin
    if (rd_valid) begin
      rx_log[rx_n % 64] = {rd_owner, rd_last, rd_data};
      rx_n++;
    end
    if (req_ack[0]) begin ack_log[ack_n % 64] = 0; ack_n++; end
    if (req_ack[1]) begin ack_log[ack_n % 64] = 1; ack_n++; end
    if (xfer_done) begin done_cnt++; done_owner = rd_owner; end
    if (!spi_cs) begin
      cs_low_total++;
      if (hi_run != 0) last_hi_run = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input int c, input logic [23:0] a, input logic [15:0] l, output bit ok);
    if (c == 0) begin req0_addr = a; req0_len = l; end
    else begin req1_addr = a; req1_len = l; end
    req_valid[c] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      step();
      if (req_ack[c]) ok = 1'b1;
    end
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      step();
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic drive_both(input int n0, input int n1, output bit ok);
    int rem0, rem1;
    rem0 = n0;
    rem1 = n1;
    req_valid[0] = (rem0 > 0);
    req_valid[1] = (rem1 > 0);
    for (int i = 0; i < 20000 && (rem0 > 0 || rem1 > 0); i++) begin
      step();
      if (req_ack[0]) begin rem0--; if (rem0 == 0) req_valid[0] = 1'b0; end
      if (req_ack[1]) begin rem1--; if (rem1 == 0) req_valid[1] = 1'b0; end
    end
    ok = (rem0 == 0 && rem1 == 0);
    req_valid = 2'b00;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst_n = 1'b0;
    repeat (3) step();
    obs = {spi_cs, spi_clk, spi_mosi, req_ack, rd_valid, rd_last, xfer_done, busy, rd_data, rd_owner};
    vec++;
    if (obs !== 18'h20000) begin err++; $display("FAIL reset_outputs: got %h, want %h", obs, 18'h20000); end
    rst_n = 1'b1;
    step();
    vec++;
    if (spi_cs !== 1'b1 || busy !== 1'b0) begin
      err++; $display("FAIL idle_after_reset: cs=%b busy=%b, want cs=1 busy=0", spi_cs, busy);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int s, d0, c0;
    miso_bytes[0] = 8'hA5;
    miso_bytes[1] = 8'h3C;
    s = rx_n; d0 = done_cnt; c0 = cs_low_total;
    send_req(0, 24'h000100, 16'd2, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL single_ack: no req_ack[0] within budget"); end
    wait_idle(ok);
    vec++;
    if (!ok) begin err++; $display("FAIL single_idle: busy did not drop within budget"); end
    vec++;
    if (cmd_word !== 32'h03000100) begin err++; $display("FAIL single_mosi: got %h, want %h", cmd_word, 32'h03000100); end
    vec++;
    if (rx_n - s !== 2) begin err++; $display("FAIL single_count: got %0d bytes, want 2", rx_n - s); end
    vec++;
    if (rx_log[s % 64] !== {1'b0, 1'b0, 8'hA5}) begin err++; $display("FAIL single_byte0: got %h, want %h", rx_log[s % 64], {1'b0, 1'b0, 8'hA5}); end
    vec++;
    if (rx_log[(s + 1) % 64] !== {1'b0, 1'b1, 8'h3C}) begin err++; $display("FAIL single_byte1: got %h, want %h", rx_log[(s + 1) % 64], {1'b0, 1'b1, 8'h3C}); end
    vec++;
    if (done_cnt - d0 !== 1 || done_owner !== 1'b0) begin
      err++; $display("FAIL single_done: got %0d pulses owner %b, want 1 owner 0", done_cnt - d0, done_owner);
    end
    vec++;
    if (cs_low_total - c0 !== 194) begin err++; $display("FAIL single_cs_low: got %0d cycles, want 194", cs_low_total - c0); end
    vec++;
    if (spi_mosi !== 1'b0 || spi_clk !== 1'b0) begin err++; $display("FAIL single_idle_pins: mosi=%b sck=%b, want 0 0", spi_mosi, spi_clk); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int s, a0, d0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    miso_bytes[0] = 8'h5A;
    req0_addr = 24'h123456; req0_len = 16'd1;
    req1_addr = 24'hABCDEF; req1_len = 16'd1;
    s = rx_n; a0 = ack_n; d0 = done_cnt;
    drive_both(1, 1, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL simul_acks: both acks not seen within budget"); end
    wait_idle(ok);
    vec++;
    if (ack_log[a0 % 64] !== 0 || ack_log[(a0 + 1) % 64] !== 1) begin
      err++; $display("FAIL simul_grant_order: got %0d,%0d, want 0,1", ack_log[a0 % 64], ack_log[(a0 + 1) % 64]);
    end
    vec++;
    if (rx_log[s % 64] !== {1'b0, 1'b1, 8'h5A} || rx_log[(s + 1) % 64] !== {1'b1, 1'b1, 8'h5A}) begin
      err++; $display("FAIL simul_owner_seq: got %h,%h, want %h,%h", rx_log[s % 64], rx_log[(s + 1) % 64], {1'b0, 1'b1, 8'h5A}, {1'b1, 1'b1, 8'h5A});
    end
    vec++;
    if (done_cnt - d0 !== 2 || cmd_word !== 32'h03ABCDEF) begin
      err++; $display("FAIL simul_done_cmd: got %0d pulses cmd %h, want 2 cmd %h", done_cnt - d0, cmd_word, 32'h03ABCDEF);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int s, a0;
    miso_bytes[0] = 8'hC3;
    req0_addr = 24'h000010; req0_len = 16'd1;
    req1_addr = 24'h000020; req1_len = 16'd1;
    s = rx_n; a0 = ack_n;
    drive_both(2, 2, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL fair_acks: four acks not seen within budget"); end
    wait_idle(ok);
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (ack_log[(a0 + i) % 64] !== i % 2) begin
        err++; $display("FAIL fair_grant_%0d: got client %0d, want %0d", i, ack_log[(a0 + i) % 64], i % 2);
      end
      vec++;
      if (rx_log[(s + i) % 64] !== {i[0], 1'b1, 8'hC3}) begin
        err++; $display("FAIL fair_byte_%0d: got %h, want %h", i, rx_log[(s + i) % 64], {i[0], 1'b1, 8'hC3});
      end
    end
  endtask

  task automatic test_len_zero();
    bit got;
    int s, d0, c0;
    s = rx_n; d0 = done_cnt; c0 = cs_low_total;
    req1_addr = 24'h000555; req1_len = 16'd0;
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (req_ack[1]) got = 1'b1;
    end
    req_valid[1] = 1'b0;
    vec++;
    if (!got) begin err++; $display("FAIL len0_ack: no req_ack[1] within budget"); end
    vec++;
    if (xfer_done !== 1'b0 || busy !== 1'b1) begin
      err++; $display("FAIL len0_ack_cycle: done=%b busy=%b, want 0 1", xfer_done, busy);
    end
    step();
    vec++;
    if (xfer_done !== 1'b1 || rd_owner !== 1'b1) begin
      err++; $display("FAIL len0_done: done=%b owner=%b, want 1 1", xfer_done, rd_owner);
    end
    repeat (10) step();
    vec++;
    if (cs_low_total !== c0 || rx_n !== s || done_cnt - d0 !== 1) begin
      err++; $display("FAIL len0_quiet: cs_low=%0d bytes=%0d dones=%0d, want 0 0 1", cs_low_total - c0, rx_n - s, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    int s, d0;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'(8'h11 * (i + 1));
    s = rx_n;
    send_req(0, 24'h00F000, 16'd8, ok);
    for (int i = 0; i < 6000 && rx_n - s < 2; i++) step();
    repeat (3) step();
    vec++;
    if (spi_cs !== 1'b0 || rx_n - s !== 2) begin
      err++; $display("FAIL mid_before: cs=%b bytes=%0d, want 0 2", spi_cs, rx_n - s);
    end
    vec++;
    if (rx_log[s % 64] !== {1'b0, 1'b0, 8'h11} || rx_log[(s + 1) % 64] !== {1'b0, 1'b0, 8'h22}) begin
      err++; $display("FAIL mid_bytes: got %h,%h, want %h,%h", rx_log[s % 64], rx_log[(s + 1) % 64], {1'b0, 1'b0, 8'h11}, {1'b0, 1'b0, 8'h22});
    end
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (spi_cs !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0) begin
      err++; $display("FAIL mid_async: cs=%b sck=%b busy=%b, want 1 0 0", spi_cs, spi_clk, busy);
    end
    repeat (3) step();
    vec++;
    if (done_cnt !== d0 || rx_n - s !== 2) begin
      err++; $display("FAIL mid_no_done: dones=%0d bytes=%0d, want 0 2", done_cnt - d0, rx_n - s);
    end
    rst_n = 1'b1;
    step();
    s = rx_n; d0 = done_cnt;
    send_req(1, 24'h000777, 16'd1, ok);
    wait_idle(ok);
    vec++;
    if (!ok || done_cnt - d0 !== 1 || rx_log[s % 64] !== {1'b1, 1'b1, 8'h11} || cmd_word !== 32'h03000777) begin
      err++; $display("FAIL mid_recover: dones=%0d byte=%h cmd=%h, want 1 %h %h", done_cnt - d0, rx_log[s % 64], cmd_word, {1'b1, 1'b1, 8'h11}, 32'h03000777);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s, d0;
    miso_bytes[0] = 8'h96;
    req0_addr = 24'h000040; req0_len = 16'd1;
    req1_addr = 24'h000080; req1_len = 16'd1;
    s = rx_n; d0 = done_cnt;
    drive_both(1, 1, ok);
    wait_idle(ok);
    vec++;
    if (!ok || done_cnt - d0 !== 2 || rx_n - s !== 2) begin
      err++; $display("FAIL b2b_done: dones=%0d bytes=%0d, want 2 2", done_cnt - d0, rx_n - s);
    end
    vec++;
    if (last_hi_run < 4) begin err++; $display("FAIL b2b_cs_gap: got %0d high cycles, want at least 4", last_hi_run); end
    vec++;
    if (rx_log[(s + 1) % 64] !== {1'b1, 1'b1, 8'h96}) begin
      err++; $display("FAIL b2b_second: got %h, want %h", rx_log[(s + 1) % 64], {1'b1, 1'b1, 8'h96});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req0_addr = '0; req1_addr = '0;
    req0_len  = '0; req1_len  = '0;
    for (int i = 0; i < 16; i++) miso_bytes[i] = 8'h00;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_len_zero();
    test_reset_mid_data();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_arbiter.md
# spi_flash_read_arbiter

Shares the single external SPI NOR flash between two read clients: client 0 is the panel frame loader and client 1 is diagnostics/UART. The block arbitrates round-robin and issues standard READ (0x03) transactions in SPI mode 0. It streams returned bytes on one shared data port tagged with the owning client. It sits between the board-level SPI flash pins and the 12bpp panel datapath.

## Interface
- CLK_DIV, 2: clk cycles per SPI clock half-period (≥1); 2 gives 6.25 MHz SCK from 25 MHz.
- LEN_W, 16: width of byte-count fields.
- CS_GAP, 4: minimum clk cycles spi_cs stays high between transactions (≥1).

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-client request; held high until the matching req_ack.
- req0_addr, req1_addr  in  24 each  flash byte address.
- req0_len, req1_len  in  LEN_W each  byte count.
- req_ack  out  2  one-cycle pulse when a request is accepted; addr/len are sampled in that cycle.
- rd_data  out  8  returned byte.
- rd_valid  out  1  one-cycle pulse per byte.
- rd_owner  out  1  client index for rd_data/rd_last/xfer_done.
- rd_last  out  1  high with the final rd_valid of a transaction.
- xfer_done  out  1  one-cycle pulse when a transaction completes, including len=0.
- busy  out  1  high from ack to the end of the CS gap.
- spi_cs  out  1  active-low chip select.
- spi_clk  out  1  SCK; idles low.
- spi_mosi  out  1  command/address out, MSB first.
- spi_miso  in  1  data in.

## Operation
- FSM states: IDLE → CS_SETUP → CMD → DATA → DONE → GAP → IDLE.
- IDLE:
  - If any req_valid is set, grant one client, pulse req_ack, and latch addr/len/owner.
  - If both are set, grant the client indicated by the rr pointer.
  - After reset the pointer favours client 0. After each grant it points to the other client.
- len=0: ack, then xfer_done in the next cycle. spi_cs stays high, there is no rd_valid, and the FSM goes directly to IDLE.
- CS_SETUP: spi_cs low, spi_mosi = bit 31 of the 32-bit word {0x03, addr[23:0]}. Duration CLK_DIV cycles.
- CMD: 32 SCK pulses.
  - MISO is sampled on the SCK rising edge. MOSI updates on the SCK falling edge.
  - spi_mosi returns to 0 after the last command bit.
- DATA: 8·len SCK pulses.
  - spi_miso is sampled on each rising edge and shifted in MSB first.
  - After the 8th bit of a byte, pulse rd_valid with that byte. Assert rd_last on the final byte.
- DONE:
  - spi_clk low, spi_cs high (CS is raised CLK_DIV cycles after the last falling SCK edge).
  - Pulse xfer_done.
- GAP: hold spi_cs high for CS_GAP cycles. Requests are not granted during GAP. Then go to IDLE.
- Byte counter is LEN_W bits and counts down. len = 2^LEN_W − 1 is legal.
- Address wrap-around past 0xFFFFFF is left to the flash device. The block does not modify the address.
- req_valid changes while busy are ignored until IDLE.

## Timing
- Reset values:
  - spi_cs=1, spi_clk=0, spi_mosi=0.
  - req_ack=0, rd_valid=0, rd_last=0, xfer_done=0, busy=0, rd_data=0, rd_owner=0.
  - rr pointer=0.
- Reset assertion mid-transaction: all of the above apply asynchronously, spi_cs rises immediately, and no xfer_done is issued.
- Request→ack: ack is registered and asserted in the cycle after req_valid is seen in IDLE.
- ack→spi_cs low: 1 cycle.
- SCK period is 2·CLK_DIV cycles with 50% duty.
- rd_valid: 1 cycle after the clk edge that samples the 8th bit.
- Total transaction length from spi_cs fall to spi_cs rise: (CLK_DIV + (32+8·len)·2·CLK_DIV) cycles.
- Back-to-back: the next ack comes at the earliest one cycle after GAP ends.
- All outputs are registered. spi_miso is used directly; no synchronizer is required because SCK is derived from clk.

## Structure
- Package spi_flash_pkg:
  - CMD_READ = 8'h03.
  - ADDR_W = 24.
  - FSM state enum.
  - Shared with the existing flash diagnostic.
- Sub-module spi_shift_engine:
  - SCK divider plus a mode-0 bit shifter with a start/nbits/done handshake.
  - Instantiated once; used for both the CMD and DATA phases.

## Test plan
- Single read: client 0 requests addr 0x000100, len 2; MISO model returns 0xA5, 0x3C.
  - MOSI carries 0x03,0x00,0x01,0x00.
  - rd_data is 0xA5 then 0x3C, with rd_owner=0 and rd_last on 0x3C.
  - xfer_done is issued once, and spi_cs is low for exactly 2+(32+16)·4 cycles.
- Simultaneous requests right after reset: both valid, len 1.
  - Client 0 is served first, then client 1.
  - The rd_owner sequence is 0,1.
- Fairness: client 0 re-requests immediately while client 1 is pending.
  - Grant order is 0,1,0,1.
  - Neither client is granted twice in a row while the other is waiting.
- len=0 on client 1:
  - req_ack is followed by xfer_done one cycle later with rd_owner=1.
  - spi_cs never goes low and there is no rd_valid.
- Reset mid-DATA:
  - Assert rst_n=0 during byte 3 of a len-8 read.
  - spi_cs=1 and spi_clk=0 in the same cycle, with no xfer_done.
  - A new request after release completes normally.
- CS gap with CS_GAP=4: two back-to-back requests.
  - spi_cs stays high for at least 4 cycles between transactions.
